// File: rtl/keccak_slice_collector.sv
// Slice-to-lane converter: gathers 64 slices of 25 bits into 25 lanes of 64 bits, then streams the lanes out.
// Optional sticky overrun detection is built when SLICE_COLLECT_OVERRUN_EN is defined.
module keccak_slice_collector #(
  parameter int SLICES = 64,
  parameter int LANES  = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LANES-1:0]  sliceIn,
  input  logic              sliceValid,
  output logic              sliceReady,
  output logic [SLICES-1:0] laneOut,
  output logic [4:0]        laneIdx,
  output logic              laneValid,
  input  logic              laneReady,
  output logic              done,
  output logic              overrun
);

  localparam int SW = $clog2(SLICES);
  localparam int LW = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   slice_cnt_q;
  logic [SW-1:0]   slice_cnt_d;
  logic [LW-1:0]   lane_cnt_q;
  logic [LW-1:0]   lane_cnt_d;
  logic            slice_last;
  logic            lane_last;
  logic            beat;

  logic [LANES-1:0][SLICES-1:0] lane_store;

  assign slice_last = (slice_cnt_q == SW'(SLICES - 1));
  assign lane_last  = (lane_cnt_q == LW'(LANES - 1));
  assign beat       = (state_q == ST_COLLECT) && sliceValid;

  always_comb begin
    slice_cnt_d = slice_last ? '0 : slice_cnt_q + SW'(1);
    lane_cnt_d  = lane_last ? '0 : lane_cnt_q + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      slice_cnt_q <= '0;
      lane_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_COLLECT;
            slice_cnt_q <= '0;
            lane_cnt_q  <= '0;
          end
        end
        ST_COLLECT: begin
          if (sliceValid) begin
            slice_cnt_q <= slice_cnt_d;
            if (slice_last) begin
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (laneReady) begin
            lane_cnt_q <= lane_cnt_d;
            if (lane_last) begin
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Each lane register takes one bit per beat, at the column selected by the slice counter.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [SLICES-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (beat && !rst) begin
        lane_q[slice_cnt_q] <= sliceIn[gi];
      end
    end

    assign lane_store[gi] = lane_q;
  end

  assign sliceReady = (state_q == ST_COLLECT);
  assign laneValid  = (state_q == ST_EMIT);
  assign done       = (state_q == ST_DONE);
  assign laneOut    = (state_q == ST_EMIT) ? lane_store[lane_cnt_q] : '0;
  assign laneIdx    = (state_q == ST_EMIT) ? lane_cnt_q : '0;

`ifdef SLICE_COLLECT_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (sliceValid && (state_q != ST_COLLECT)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_slice_collector.sv
// Directed bench for keccak_slice_collector: round trip, bit mapping, stalls, resets, overrun and start handling.
module tb_keccak_slice_collector;

`ifdef SLICE_COLLECT_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [24:0] slice_in;
  logic        slice_valid;
  logic        slice_ready;
  logic [63:0] lane_out;
  logic [4:0]  lane_idx;
  logic        lane_valid;
  logic        lane_ready;
  logic        done;
  logic        overrun;

  keccak_slice_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sliceIn    (slice_in),
    .sliceValid (slice_valid),
    .sliceReady (slice_ready),
    .laneOut    (lane_out),
    .laneIdx    (lane_idx),
    .laneValid  (lane_valid),
    .laneReady  (lane_ready),
    .done       (done),
    .overrun    (overrun)
  );

  int errors = 0;
  int checks = 0;
  int edges  = 0;
  int start_edge;
  int done_edge;
  int got_n;
  int stall_rem;
  int stall_bad;
  logic [24:0] slice_pat [64];
  logic [63:0] got_lane [25];
  logic [4:0]  got_idx [25];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_alt();
    for (int z = 0; z < 64; z++) slice_pat[z] = {25{z[0]}};
  endtask

  task automatic do_start(input bit hold);
    @(posedge clk); #1;
    start = 1'b1;
    start_edge = edges;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int z = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit rdy;
    bit vv;
    while (z < n && guard < 400) begin
      slice_valid = gaps ? tog : 1'b1;
      slice_in = slice_pat[z];
      tog = ~tog;
      rdy = slice_ready;
      vv = slice_valid;
      @(posedge clk); #1;
      if (rdy && vv) z++;
      guard++;
    end
    slice_valid = 1'b0;
    checks++;
    if (z !== n) begin
      errors++;
      $display("FAIL feed_beats: accepted %0d required %0d", z, n);
    end
  endtask

  task automatic recv(input int stall_lane, input int stall_len, input bit poke);
    bit armed = 1'b0;
    bit poked = 1'b0;
    logic [63:0] hold_out = '0;
    logic [4:0] hold_idx = '0;
    got_n = 0;
    done_edge = -1;
    stall_rem = stall_len;
    stall_bad = 0;
    for (int g = 0; g < 200; g++) begin
      if (done) begin
        done_edge = edges;
        break;
      end
      if (lane_valid && stall_rem > 0 && (armed || lane_idx == 5'(stall_lane))) begin
        if (!armed) begin
          armed = 1'b1;
          hold_out = lane_out;
          hold_idx = lane_idx;
        end else if (lane_out !== hold_out || lane_idx !== hold_idx) begin
          stall_bad++;
        end
        lane_ready = 1'b0;
        stall_rem--;
      end else begin
        if (armed && lane_valid && (lane_out !== hold_out || lane_idx !== hold_idx)) stall_bad++;
        armed = 1'b0;
        lane_ready = 1'b1;
      end
      if (poke && lane_valid && !poked) begin
        slice_valid = 1'b1;
        slice_in = '1;
        poked = 1'b1;
      end else begin
        slice_valid = 1'b0;
      end
      if (lane_valid && lane_ready) begin
        if (got_n < 25) begin
          got_lane[got_n] = lane_out;
          got_idx[got_n] = lane_idx;
        end
        got_n++;
      end
      @(posedge clk); #1;
    end
    lane_ready = 1'b0;
    slice_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (slice_ready !== 1'b0) begin errors++; $display("FAIL reset_sliceReady: got %b want 0", slice_ready); end
    checks++; if (lane_valid !== 1'b0) begin errors++; $display("FAIL reset_laneValid: got %b want 0", lane_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (lane_out !== 64'h0) begin errors++; $display("FAIL reset_laneOut: got %h want 0", lane_out); end
    checks++; if (lane_idx !== 5'd0) begin errors++; $display("FAIL reset_laneIdx: got %0d want 0", lane_idx); end
    @(posedge clk); #1;
    checks++; if (slice_ready !== 1'b0) begin errors++; $display("FAIL idle_sliceReady: got %b want 0", slice_ready); end
  endtask

  task automatic test_basic();
    fill_alt();
    do_start(1'b0);
    checks++; if (slice_ready !== 1'b1) begin errors++; $display("FAIL basic_collect_ready: got %b want 1", slice_ready); end
    feed(64, 1'b0);
    recv(-1, 0, 1'b0);
    checks++; if (got_n !== 25) begin errors++; $display("FAIL basic_lane_count: got %0d want 25", got_n); end
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (got_idx[i] !== 5'(i) || got_lane[i] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
        errors++;
        $display("FAIL basic_lane%0d: got idx %0d data %h want idx %0d data aaaaaaaaaaaaaaaa", i, got_idx[i], got_lane[i], i);
      end
    end
    checks++; if (done_edge - start_edge !== 90) begin errors++; $display("FAIL basic_done_latency: got %0d want 90", done_edge - start_edge); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || lane_valid !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done %b valid %b want 0 0", done, lane_valid); end
    checks++; if (lane_out !== 64'h0 || lane_idx !== 5'd0) begin errors++; $display("FAIL basic_idle_outputs: got %h/%0d want 0/0", lane_out, lane_idx); end
  endtask

  task automatic test_bit_mapping();
    logic [63:0] exp;
    for (int z = 0; z < 64; z++) slice_pat[z] = 25'h1 << (z % 25);
    do_start(1'b0);
    feed(64, 1'b0);
    recv(-1, 0, 1'b0);
    checks++; if (got_lane[0] !== 64'h0004_0000_0200_0001) begin errors++; $display("FAIL map_lane0: got %h want 0004000002000001", got_lane[0]); end
    checks++; if (got_lane[24] !== 64'h0002_0000_0100_0000) begin errors++; $display("FAIL map_lane24: got %h want 0002000001000000", got_lane[24]); end
    for (int i = 0; i < 25; i++) begin
      exp = '0;
      for (int z = 0; z < 64; z++) if (z % 25 == i) exp[z] = 1'b1;
      checks++;
      if (got_lane[i] !== exp) begin errors++; $display("FAIL map_lane%0d: got %h want %h", i, got_lane[i], exp); end
    end
  endtask

  task automatic test_stalls();
    fill_alt();
    do_start(1'b0);
    feed(64, 1'b1);
    recv(7, 3, 1'b0);
    checks++; if (got_n !== 25) begin errors++; $display("FAIL stall_lane_count: got %0d want 25", got_n); end
    checks++; if (stall_rem !== 0 || stall_bad !== 0) begin errors++; $display("FAIL stall_hold: remaining %0d unstable %0d want 0 0", stall_rem, stall_bad); end
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (got_idx[i] !== 5'(i) || got_lane[i] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
        errors++;
        $display("FAIL stall_lane%0d: got idx %0d data %h want idx %0d data aaaaaaaaaaaaaaaa", i, got_idx[i], got_lane[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    fill_alt();
    do_start(1'b0);
    feed(30, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (slice_ready !== 1'b0 || lane_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle: got ready %b valid %b want 0 0", slice_ready, lane_valid); end
    for (int c = 0; c < 6; c++) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
    for (int z = 0; z < 64; z++) slice_pat[z] = '1;
    do_start(1'b0);
    feed(64, 1'b0);
    recv(-1, 0, 1'b0);
    checks++; if (got_n !== 25) begin errors++; $display("FAIL midrst_lane_count: got %0d want 25", got_n); end
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (got_lane[i] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL midrst_lane%0d: got %h want ffffffffffffffff", i, got_lane[i]); end
    end
    checks++; if (done_edge - start_edge !== 90) begin errors++; $display("FAIL midrst_latency: got %0d want 90", done_edge - start_edge); end
  endtask

  task automatic test_overrun();
    fill_alt();
    do_start(1'b0);
    feed(64, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b want 0", overrun); end
    recv(-1, 0, 1'b1);
    checks++; if (overrun !== OVR_EN) begin errors++; $display("FAIL ovr_set: got %b want %b", overrun, OVR_EN); end
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (got_lane[i] !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL ovr_lane%0d: got %h want aaaaaaaaaaaaaaaa", i, got_lane[i]); end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (overrun !== OVR_EN) begin errors++; $display("FAIL ovr_sticky: got %b want %b", overrun, OVR_EN); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b want 0", overrun); end
  endtask

  task automatic test_start_handling();
    fill_alt();
    do_start(1'b1);
    feed(64, 1'b0);
    recv(-1, 0, 1'b0);
    checks++; if (done_edge - start_edge !== 90) begin errors++; $display("FAIL start_no_restart: got latency %0d want 90", done_edge - start_edge); end
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (got_lane[i] !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL start_lane%0d: got %h want aaaaaaaaaaaaaaaa", i, got_lane[i]); end
    end
    @(posedge clk); #1;
    checks++; if (slice_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_idle_after_done: got ready %b done %b want 0 0", slice_ready, done); end
    @(posedge clk); #1;
    checks++; if (slice_ready !== 1'b1) begin errors++; $display("FAIL start_recollect: got ready %b want 1", slice_ready); end
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    slice_in = '0;
    slice_valid = 1'b0;
    lane_ready = 1'b0;
    test_reset();
    test_basic();
    test_bit_mapping();
    test_stalls();
    test_reset_mid();
    test_overrun();
    test_start_handling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
